// File: rtl/note_judge.sv
// note_judge: rhythm-game judge. Plays a 16-slot, 2-bit-per-slot note pattern
// one slot per beat and scores the player's lane button presses against it.
module note_judge #(
   parameter int unsigned BEAT_DIV = 1000
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [31:0] song,
   input  logic [2:0]  buttons,
   output logic [1:0]  target,
   output logic [7:0]  score,
   output logic [4:0]  combo,
   output logic [4:0]  misses,
   output logic        playing,
   output logic        done
);

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_PLAY   = 2'd1;
   localparam logic [1:0]  ST_DONE   = 2'd2;
   localparam logic [15:0] LAST_BEAT = 16'(BEAT_DIV - 1);

   logic [1:0]  state_q,    state_d;
   logic [15:0] cnt_q,      cnt_d;
   logic [3:0]  slot_q,     slot_d;
   logic [31:0] shift_q,    shift_d;
   logic [7:0]  score_q,    score_d;
   logic [4:0]  combo_q,    combo_d;
   logic [4:0]  misses_q,   misses_d;
   logic        lock_q,     lock_d;
   logic [2:0]  btn_prev_q, btn_prev_d;

   logic [2:0]  press;
   logic        tick;
   logic        judged;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [4:0] sat_inc5(input logic [4:0] v);
      return (v == 5'h1F) ? v : v + 5'd1;
   endfunction

   // Lane encoding 1..3 maps to button bit 0..2.
   function automatic logic [2:0] lane_onehot(input logic [1:0] note);
      case (note)
         2'd1:    return 3'b001;
         2'd2:    return 3'b010;
         2'd3:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Next-state: start/latch, per-cycle press judgement, beat advance.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      slot_d     = slot_q;
      shift_d    = shift_q;
      score_d    = score_q;
      combo_d    = combo_q;
      misses_d   = misses_q;
      lock_d     = lock_q;
      btn_prev_d = buttons;
      press      = buttons & ~btn_prev_q;
      tick       = 1'b0;
      judged     = 1'b0;

      case (state_q)
         ST_PLAY: begin
            tick  = (cnt_q == LAST_BEAT);
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

            // A press is judged at most once per slot; rests only break the combo.
            if (!lock_q && (press != 3'b000)) begin
               if (shift_q[1:0] == 2'd0) begin
                  combo_d = 5'd0;
               end else begin
                  judged = 1'b1;
                  lock_d = 1'b1;
                  if (press == lane_onehot(shift_q[1:0])) begin
                     score_d = sat_inc8(score_q);
                     combo_d = sat_inc5(combo_q);
                  end else begin
                     misses_d = sat_inc5(misses_q);
                     combo_d  = 5'd0;
                  end
               end
            end

            // The outgoing slot is judged above before the tick advances the pattern.
            if (tick) begin
               if ((shift_q[1:0] != 2'd0) && !lock_q && !judged) begin
                  misses_d = sat_inc5(misses_q);
                  combo_d  = 5'd0;
               end
               shift_d = {2'b00, shift_q[31:2]};
               slot_d  = slot_q + 4'd1;
               lock_d  = 1'b0;
               if (slot_q == 4'd15) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            if (start) begin
               state_d  = ST_PLAY;
               shift_d  = song;
               cnt_d    = 16'd0;
               slot_d   = 4'd0;
               score_d  = 8'd0;
               combo_d  = 5'd0;
               misses_d = 5'd0;
               lock_d   = 1'b0;
            end
         end
      endcase
   end

   // State registers; reset clears everything, including mid-play.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 16'd0;
         slot_q     <= 4'd0;
         shift_q    <= 32'd0;
         score_q    <= 8'd0;
         combo_q    <= 5'd0;
         misses_q   <= 5'd0;
         lock_q     <= 1'b0;
         btn_prev_q <= 3'b000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         slot_q     <= slot_d;
         shift_q    <= shift_d;
         score_q    <= score_d;
         combo_q    <= combo_d;
         misses_q   <= misses_d;
         lock_q     <= lock_d;
         btn_prev_q <= btn_prev_d;
      end
   end

   assign target  = (state_q == ST_PLAY) ? shift_q[1:0] : 2'd0;
   assign score   = score_q;
   assign combo   = combo_q;
   assign misses  = misses_q;
   assign playing = (state_q == ST_PLAY);
   assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed scenarios plus randomized play-throughs checked
// against a slot/cycle-level behavioural model of the judge.
module tb_note_judge;

   localparam int BD = 4;

   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic [31:0] song;
   logic [2:0]  buttons;
   logic [1:0]  target;
   logic [7:0]  score;
   logic [4:0]  combo;
   logic [4:0]  misses;
   logic        playing;
   logic        done;

   int total = 0;
   int bad   = 0;

   note_judge #(.BEAT_DIV(BD)) dut (
      .clk     (clk),
      .nrst    (nrst),
      .start   (start),
      .song    (song),
      .buttons (buttons),
      .target  (target),
      .score   (score),
      .combo   (combo),
      .misses  (misses),
      .playing (playing),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Reference model: position in the song is a plain cycle count since start.
   typedef struct packed {
      logic        play;
      logic        fin;
      logic [31:0] cyc;
      logic [31:0] sng;
      logic [31:0] sc;
      logic [31:0] co;
      logic [31:0] mi;
      logic        judged;
      logic [2:0]  prev;
   } model_t;

   model_t m;

   function automatic logic [1:0] note_at(input model_t s);
      int slot;
      slot = int'(s.cyc) / BD;
      return 2'((s.sng >> (2 * slot)) & 32'd3);
   endfunction

   function automatic logic [1:0] model_target(input model_t s);
      return s.play ? note_at(s) : 2'd0;
   endfunction

   function automatic model_t model_next(input model_t s, input logic [2:0] b,
                                         input logic st, input logic [31:0] sg);
      model_t     n;
      logic [2:0] pr;
      logic [1:0] nt;
      int         slot;
      logic       last;
      n      = s;
      pr     = b & ~s.prev;
      n.prev = b;
      if (!s.play) begin
         if (st) begin
            n.play = 1'b1; n.fin = 1'b0; n.cyc = 0; n.sng = sg;
            n.sc = 0; n.co = 0; n.mi = 0; n.judged = 1'b0;
         end
      end else begin
         slot = int'(s.cyc) / BD;
         nt   = note_at(s);
         last = ((int'(s.cyc) % BD) == BD - 1);
         if (pr != 3'b000 && !s.judged) begin
            if (nt == 2'd0) begin
               n.co = 0;
            end else if (pr == (3'b001 << (nt - 2'd1))) begin
               n.sc = (s.sc < 255) ? s.sc + 1 : 255;
               n.co = (s.co < 31) ? s.co + 1 : 31;
               n.judged = 1'b1;
            end else begin
               n.mi = (s.mi < 31) ? s.mi + 1 : 31;
               n.co = 0;
               n.judged = 1'b1;
            end
         end
         if (last) begin
            if (nt != 2'd0 && !n.judged) begin
               n.mi = (n.mi < 31) ? n.mi + 1 : 31;
               n.co = 0;
            end
            n.judged = 1'b0;
            if (slot == 15) begin
               n.play = 1'b0;
               n.fin  = 1'b1;
            end
         end
         n.cyc = s.cyc + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) m <= '0;
      else       m <= model_next(m, buttons, start, song);
   end

   // Leaves the bench at the falling edge of play cycle 0.
   task automatic do_start(input logic [31:0] s);
      @(negedge clk);
      song  = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      nrst = 1'b0; start = 1'b0; song = 32'd0; buttons = 3'b000;
      repeat (2) @(negedge clk);
      total++; if (target  !== 2'd0) begin bad++; $display("FAIL rst_target: got %0d expected 0", target); end
      total++; if (score   !== 8'd0) begin bad++; $display("FAIL rst_score: got %0d expected 0", score); end
      total++; if (combo   !== 5'd0) begin bad++; $display("FAIL rst_combo: got %0d expected 0", combo); end
      total++; if (misses  !== 5'd0) begin bad++; $display("FAIL rst_misses: got %0d expected 0", misses); end
      total++; if (playing !== 1'b0) begin bad++; $display("FAIL rst_playing: got %0d expected 0", playing); end
      total++; if (done    !== 1'b0) begin bad++; $display("FAIL rst_done: got %0d expected 0", done); end
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (playing !== 1'b0) begin bad++; $display("FAIL idle_hold_playing: got %0d expected 0", playing); end
      total++; if (done    !== 1'b0) begin bad++; $display("FAIL idle_hold_done: got %0d expected 0", done); end
   endtask

   task automatic test_hits;
      int found;
      found = -1;
      do_start(32'h0000_001B);
      total++; if (playing !== 1'b1) begin bad++; $display("FAIL hits_playing: got %0d expected 1", playing); end
      total++; if (target !== 2'd3) begin bad++; $display("FAIL hits_target0: got %0d expected 3", target); end
      for (int k = 0; k < 72; k++) begin
         if (done === 1'b1 && found < 0) found = k;
         buttons = (k == 1) ? 3'b100 : (k == 5) ? 3'b010 : (k == 9) ? 3'b001 : 3'b000;
         @(negedge clk);
      end
      total++; if (found != 64) begin bad++; $display("FAIL hits_done_latency: got %0d expected 64", found); end
      total++; if (score  !== 8'd3) begin bad++; $display("FAIL hits_score: got %0d expected 3", score); end
      total++; if (combo  !== 5'd3) begin bad++; $display("FAIL hits_combo: got %0d expected 3", combo); end
      total++; if (misses !== 5'd0) begin bad++; $display("FAIL hits_misses: got %0d expected 0", misses); end
   endtask

   task automatic test_all_miss;
      do_start(32'h5555_5555);
      repeat (70) @(negedge clk);
      total++; if (misses !== 5'd16) begin bad++; $display("FAIL allmiss_misses: got %0d expected 16", misses); end
      total++; if (score  !== 8'd0)  begin bad++; $display("FAIL allmiss_score: got %0d expected 0", score); end
      total++; if (combo  !== 5'd0)  begin bad++; $display("FAIL allmiss_combo: got %0d expected 0", combo); end
      total++; if (done   !== 1'b1)  begin bad++; $display("FAIL allmiss_done: got %0d expected 1", done); end
   endtask

   task automatic test_wrong_press;
      do_start(32'h0000_0003);
      @(negedge clk);
      buttons = 3'b001;
      @(negedge clk);
      total++; if (misses !== 5'd1) begin bad++; $display("FAIL wrong_misses_now: got %0d expected 1", misses); end
      buttons = 3'b101;
      @(negedge clk);
      buttons = 3'b000;
      @(negedge clk);
      @(negedge clk);
      total++; if (misses !== 5'd1) begin bad++; $display("FAIL wrong_misses_tick: got %0d expected 1", misses); end
      total++; if (score  !== 8'd0) begin bad++; $display("FAIL wrong_score: got %0d expected 0", score); end
      total++; if (combo  !== 5'd0) begin bad++; $display("FAIL wrong_combo: got %0d expected 0", combo); end
      repeat (64) @(negedge clk);
      total++; if (misses !== 5'd1) begin bad++; $display("FAIL wrong_misses_end: got %0d expected 1", misses); end
   endtask

   task automatic test_tick_press;
      do_start(32'h0000_0001);
      repeat (3) @(negedge clk);
      buttons = 3'b001;
      @(negedge clk);
      total++; if (score  !== 8'd1) begin bad++; $display("FAIL tick_score: got %0d expected 1", score); end
      total++; if (misses !== 5'd0) begin bad++; $display("FAIL tick_misses: got %0d expected 0", misses); end
      repeat (6) @(negedge clk);
      total++; if (combo  !== 5'd1) begin bad++; $display("FAIL tick_hold_combo: got %0d expected 1", combo); end
      buttons = 3'b000;
      repeat (60) @(negedge clk);
      total++; if (score  !== 8'd1) begin bad++; $display("FAIL tick_end_score: got %0d expected 1", score); end
      total++; if (misses !== 5'd0) begin bad++; $display("FAIL tick_end_misses: got %0d expected 0", misses); end
   endtask

   task automatic test_reset_mid;
      do_start(32'h0000_001B);
      for (int k = 0; k < 8; k++) begin
         buttons = (k == 1) ? 3'b100 : (k == 5) ? 3'b010 : 3'b000;
         @(negedge clk);
      end
      total++; if (score !== 8'd2) begin bad++; $display("FAIL mid_score_before: got %0d expected 2", score); end
      #2 nrst = 1'b0;
      #1;
      total++; if (score   !== 8'd0) begin bad++; $display("FAIL mid_async_score: got %0d expected 0", score); end
      total++; if (combo   !== 5'd0) begin bad++; $display("FAIL mid_async_combo: got %0d expected 0", combo); end
      total++; if (target  !== 2'd0) begin bad++; $display("FAIL mid_async_target: got %0d expected 0", target); end
      total++; if (playing !== 1'b0) begin bad++; $display("FAIL mid_async_playing: got %0d expected 0", playing); end
      @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (playing !== 1'b0) begin bad++; $display("FAIL mid_idle_playing: got %0d expected 0", playing); end
      do_start(32'h0000_001B);
      total++; if (playing !== 1'b1) begin bad++; $display("FAIL mid_restart_playing: got %0d expected 1", playing); end
      total++; if (score   !== 8'd0) begin bad++; $display("FAIL mid_restart_score: got %0d expected 0", score); end
      total++; if (target  !== 2'd3) begin bad++; $display("FAIL mid_restart_target: got %0d expected 3", target); end
      repeat (70) @(negedge clk);
      total++; if (misses  !== 5'd3) begin bad++; $display("FAIL mid_restart_misses: got %0d expected 3", misses); end
      total++; if (done    !== 1'b1) begin bad++; $display("FAIL mid_restart_done: got %0d expected 1", done); end
   endtask

   task automatic test_random;
      logic [1:0] t;
      for (int it = 0; it < 8; it++) begin
         do_start($urandom);
         for (int k = 0; k < 72; k++) begin
            total++; if (target  !== model_target(m)) begin bad++; $display("FAIL rnd_target it=%0d k=%0d: got %0d expected %0d", it, k, target, model_target(m)); end
            total++; if (score   !== m.sc[7:0])       begin bad++; $display("FAIL rnd_score it=%0d k=%0d: got %0d expected %0d", it, k, score, m.sc[7:0]); end
            total++; if (combo   !== m.co[4:0])       begin bad++; $display("FAIL rnd_combo it=%0d k=%0d: got %0d expected %0d", it, k, combo, m.co[4:0]); end
            total++; if (misses  !== m.mi[4:0])       begin bad++; $display("FAIL rnd_misses it=%0d k=%0d: got %0d expected %0d", it, k, misses, m.mi[4:0]); end
            total++; if (playing !== m.play)          begin bad++; $display("FAIL rnd_playing it=%0d k=%0d: got %0d expected %0d", it, k, playing, m.play); end
            total++; if (done    !== m.fin)           begin bad++; $display("FAIL rnd_done it=%0d k=%0d: got %0d expected %0d", it, k, done, m.fin); end
            t = model_target(m);
            case ($urandom % 8)
               0, 1, 2, 3: buttons = 3'b000;
               4, 5:       buttons = (t != 2'd0) ? (3'b001 << (t - 2'd1)) : 3'b000;
               6:          buttons = 3'($urandom);
               default:    buttons = buttons;
            endcase
            song  = $urandom;
            start = (($urandom % 16) == 0);
            @(negedge clk);
         end
         start   = 1'b0;
         buttons = 3'b000;
      end
   endtask

   initial begin
      test_reset();
      test_hits();
      test_all_miss();
      test_wrong_press();
      test_tick_press();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/note_judge.md
NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 Parameter BEAT_DIV, default 1000, clock cycles per beat (slot duration); legal range 2..65535.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 nrst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle pulse, begins a play-through.
REQ-005 song  input  32  note pattern from the song display stage: 16 slots, slot i = song[2i+1:2i], slot 0 played first.
REQ-006 buttons  input  3  player lane buttons, level, already synchronised.
REQ-007 target  output  2  note under judgement: 0 rest, 1 lane0, 2 lane1, 3 lane2.
REQ-008 score  output  8  hit count, saturating.
REQ-009 combo  output  5  consecutive hits, saturating.
REQ-010 misses  output  5  miss count, saturating.
REQ-011 playing  output  1  high while in PLAY.
REQ-012 done  output  1  high while in DONE.

Function
REQ-013 The FSM SHALL have states IDLE, PLAY, DONE.
REQ-014 IDLE or DONE with start=1: next cycle enters PLAY; song latched into 32-bit shift register; beat counter, slot index (0..15), score, combo, misses, hit_lock cleared.
REQ-015 start in PLAY SHALL be ignored.
REQ-016 In PLAY, the beat counter SHALL count 0..BEAT_DIV-1 and wrap; beat tick = counter at BEAT_DIV-1.
REQ-017 target SHALL equal shift_reg[1:0] in PLAY, 0 in IDLE/DONE.
REQ-018 A press SHALL be a rising edge per lane: buttons & ~buttons_prev; buttons_prev registered every cycle in all states.
REQ-019 In PLAY with hit_lock=0, any press SHALL be judged against target that cycle; with hit_lock=1, presses SHALL be ignored.
REQ-020 Hit: target!=0 and the press vector is exactly the one-hot of lane target-1 -> score+1 (hold at 255), combo+1 (hold at 31), hit_lock=1.
REQ-021 Wrong press: target!=0 and press vector is not that one-hot -> misses+1 (hold at 31), combo=0, hit_lock=1.
REQ-022 Press on rest (target=0) -> combo=0 only; hit_lock unchanged, no miss.
REQ-023 On beat tick: if target!=0 and hit_lock=0 and no hit/wrong judged that cycle -> misses+1 (saturating), combo=0; then shift_reg shifts right by 2 (zero-fill), slot index+1, hit_lock=0.
REQ-024 A press coinciding with the beat tick SHALL be judged against the outgoing slot first; a hit on that cycle SHALL NOT also count a miss.
REQ-025 Beat tick with slot index 15 SHALL perform REQ-023 then enter DONE; PLAY lasts exactly 16*BEAT_DIV cycles.
REQ-026 DONE SHALL hold score, combo, misses unchanged until start or reset.
REQ-027 Changes to song outside the start cycle SHALL have no effect.

Reset
REQ-028 nrst=0 SHALL immediately force IDLE and zero all outputs, counters, shift register, hit_lock and buttons_prev, including mid-PLAY.
REQ-029 After nrst release the block SHALL stay in IDLE until start.

Verification (BEAT_DIV=4)
REQ-030 Assert nrst=0 -> target=0, score=0, combo=0, misses=0, playing=0, done=0.
REQ-031 song=32'h0000_001B, start; press buttons[2] in slot0, buttons[1] in slot1, buttons[0] in slot2 -> score=3, combo=3, misses=0; done=1 exactly 64 cycles after playing rises.
REQ-032 song=32'h5555_5555, start, no presses -> misses=16, score=0, combo=0 at done.
REQ-033 song=32'h0000_0003, press buttons[0] in slot0, then buttons[2] same slot -> misses=1 immediately, second press ignored, no extra miss at tick, combo=0.
REQ-034 song=32'h0000_0001, rising edge of buttons[0] on the beat-tick cycle of slot0 -> score=1, misses=0; buttons[0] held high into slot1 produces no further press.
REQ-035 Mid-PLAY after two hits, pulse nrst=0 -> all outputs 0 asynchronously; after release, start begins a fresh play with score=0.
